dcache_axi_bridge: RTL and testbench

- Downstream neighbour of the data cache. Converts the cache's memory-side SRAM-like interface (strobe/rw/ready, held until ready) into single-beat AXI4 read and write transactions toward the system interconnect.
- Serves both cached line refills/write-backs and uncached (kseg1) accesses, one outstanding transaction at a time.

---
 rtl/dcache_axi_bridge_pkg.sv | 31 +++
 rtl/dcache_axi_bridge.sv | 141 ++++++++++++++
 tb/tb_dcache_axi_bridge.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_axi_bridge_pkg.sv
// Shared types and AXI constants for the data-cache to AXI4 single-beat bridge.
package dcache_axi_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrReq,
    StWrResp,
    StDone
  } bridge_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  // Cache size code (0=byte, 1=half, 2=word) maps directly onto AxSIZE.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

  // SLVERR and DECERR both have bit 1 set.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/dcache_axi_bridge.sv
// Converts the data cache's strobe/ready memory port into single-beat AXI4 read and
// write transactions, one outstanding at a time.
module dcache_axi_bridge
  import dcache_axi_bridge_pkg::*;
#(
  parameter int unsigned A_WIDTH = 32,
  parameter int unsigned D_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [A_WIDTH-1:0]   req_a,
  input  logic [D_WIDTH-1:0]   req_din,
  output logic [D_WIDTH-1:0]   req_dout,
  input  logic                 req_strobe,
  input  logic [D_WIDTH/8-1:0] req_wen,
  input  logic [1:0]           req_size,
  input  logic                 req_rw,
  output logic                 req_ready,
  output logic [A_WIDTH-1:0]   araddr,
  output logic [2:0]           arsize,
  output logic                 arvalid,
  input  logic                 arready,
  input  logic [D_WIDTH-1:0]   rdata,
  input  logic [1:0]           rresp,
  input  logic                 rvalid,
  output logic                 rready,
  output logic [A_WIDTH-1:0]   awaddr,
  output logic [2:0]           awsize,
  output logic                 awvalid,
  input  logic                 awready,
  output logic [D_WIDTH-1:0]   wdata,
  output logic [D_WIDTH/8-1:0] wstrb,
  output logic                 wvalid,
  input  logic                 wready,
  input  logic [1:0]           bresp,
  input  logic                 bvalid,
  output logic                 bready,
  output logic                 bus_err
);

  bridge_state_e state_q, state_d;

  logic [A_WIDTH-1:0]   addr_q;
  logic [D_WIDTH-1:0]   din_q;
  logic [D_WIDTH/8-1:0] wen_q;
  logic [1:0]           size_q;
  logic [D_WIDTH-1:0]   dout_q;
  logic                 aw_done_q, w_done_q;
  logic                 bus_err_q;

  logic aw_hs, w_hs, r_hs, b_hs;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign r_hs  = rvalid & rready;
  assign b_hs  = bvalid & bready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_strobe) state_d = req_rw ? StWrReq : StRdAddr;
      StRdAddr: if (arready) state_d = StRdData;
      StRdData: if (rvalid) state_d = StDone;
      StWrReq:  if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = StWrResp;
      StWrResp: if (bvalid) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Valids and readies depend only on registered state, never on AXI inputs.
  always_comb begin
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    req_ready = 1'b0;
    unique case (state_q)
      StRdAddr: arvalid = 1'b1;
      StRdData: rready  = 1'b1;
      StWrReq: begin
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
      end
      StWrResp: bready    = 1'b1;
      StDone:   req_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      din_q     <= '0;
      wen_q     <= '0;
      size_q    <= '0;
      dout_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (state_q == StIdle && req_strobe) begin
        addr_q    <= req_a;
        din_q     <= req_din;
        wen_q     <= req_wen;
        size_q    <= req_size;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (state_q == StWrReq) begin
        aw_done_q <= aw_done_q | aw_hs;
        w_done_q  <= w_done_q | w_hs;
      end
      if (r_hs) begin
        dout_q <= rdata;
      end
      if ((r_hs && resp_is_err(rresp)) || (b_hs && resp_is_err(bresp))) begin
        bus_err_q <= 1'b1;
      end
    end
  end

  assign araddr   = addr_q;
  assign awaddr   = addr_q;
  assign arsize   = axi_size(size_q);
  assign awsize   = axi_size(size_q);
  assign wdata    = din_q;
  assign wstrb    = wen_q;
  assign req_dout = dout_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Self-checking bench: directed latency/ordering cases plus randomized traffic against a
// reference word memory, with a randomly stalling AXI slave.
module tb_dcache_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_a, req_din, req_dout;
  logic        req_strobe, req_rw, req_ready;
  logic [3:0]  req_wen;
  logic [1:0]  req_size;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;
  logic        bus_err;

  dcache_axi_bridge #(.A_WIDTH(32), .D_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_din(req_din), .req_dout(req_dout), .req_strobe(req_strobe),
    .req_wen(req_wen), .req_size(req_size), .req_rw(req_rw), .req_ready(req_ready),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave configuration and the request currently expected on the bus.
  int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
  logic [1:0]  r_resp_cfg, b_resp_cfg;
  logic [31:0] cur_addr, cur_din;
  logic [3:0]  cur_wen;
  logic [1:0]  cur_size;

  logic [31:0] smem    [16];
  logic [31:0] ref_mem [16];
  logic        berr_exp;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // AXI slave: decisions made at negedge, handshakes take effect at the following posedge.
  initial begin
    int cnt_ar, cnt_r, cnt_aw, cnt_w, cnt_b;
    bit ar_fire, r_fire, aw_fire, w_fire, b_fire;
    bit r_pend, aw_got, w_got, b_pend, ar_wait, aw_wait, w_wait;
    logic [31:0] r_addr, wa_addr, w_data;
    logic [3:0]  w_strb;
    {arready, rvalid, awready, wready, bvalid} = '0;
    rdata = '0; rresp = '0; bresp = '0;
    {ar_fire, r_fire, aw_fire, w_fire, b_fire, r_pend, aw_got, w_got, b_pend} = '0;
    {ar_wait, aw_wait, w_wait} = '0;
    {cnt_ar, cnt_r, cnt_aw, cnt_w, cnt_b} = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        {arready, rvalid, awready, wready, bvalid} = '0;
        rresp = '0; bresp = '0;
        {ar_fire, r_fire, aw_fire, w_fire, b_fire, r_pend, aw_got, w_got, b_pend} = '0;
        {ar_wait, aw_wait, w_wait} = '0;
        {cnt_ar, cnt_r, cnt_aw, cnt_w, cnt_b} = '0;
        continue;
      end
      if (ar_fire) begin r_pend = 1'b1; cnt_r = 0; end
      if (r_fire)  r_pend = 1'b0;
      if (aw_fire) aw_got = 1'b1;
      if (w_fire)  w_got  = 1'b1;
      if (b_fire)  b_pend = 1'b0;
      if (aw_got && w_got) begin
        smem[wa_addr[5:2]] = merge(smem[wa_addr[5:2]], w_data, w_strb);
        {aw_got, w_got} = '0;
        b_pend = 1'b1;
        cnt_b  = 0;
      end
      {ar_fire, r_fire, aw_fire, w_fire, b_fire} = '0;

      if (ar_wait) check_eq("arvalid_hold", 32'(arvalid), 32'd1);
      if (aw_wait) check_eq("awvalid_hold", 32'(awvalid), 32'd1);
      if (w_wait)  check_eq("wvalid_hold", 32'(wvalid), 32'd1);
      if (aw_got)  check_eq("awvalid_drop", 32'(awvalid), 32'd0);
      if (w_got)   check_eq("wvalid_drop", 32'(wvalid), 32'd0);
      if (bready)  check_eq("bready_order", 32'({awvalid, wvalid}), 32'd0);

      arready = 1'b0; ar_wait = 1'b0;
      if (arvalid) begin
        if (cnt_ar >= ar_dly) begin
          arready = 1'b1; ar_fire = 1'b1; cnt_ar = 0;
          check_eq("araddr", araddr, cur_addr);
          check_eq("arsize", 32'(arsize), 32'({1'b0, cur_size}));
          r_addr = araddr;
        end else begin
          cnt_ar++; ar_wait = 1'b1;
        end
      end

      rvalid = 1'b0; rresp = '0; rdata = $urandom;
      if (r_pend) begin
        if (cnt_r >= r_dly) begin
          rvalid = 1'b1; rdata = smem[r_addr[5:2]]; rresp = r_resp_cfg; r_fire = rready;
        end else cnt_r++;
      end

      awready = 1'b0; aw_wait = 1'b0;
      if (awvalid && !aw_got) begin
        if (cnt_aw >= aw_dly) begin
          awready = 1'b1; aw_fire = 1'b1; cnt_aw = 0;
          check_eq("awaddr", awaddr, cur_addr);
          check_eq("awsize", 32'(awsize), 32'({1'b0, cur_size}));
          wa_addr = awaddr;
        end else begin
          cnt_aw++; aw_wait = 1'b1;
        end
      end

      wready = 1'b0; w_wait = 1'b0;
      if (wvalid && !w_got) begin
        if (cnt_w >= w_dly) begin
          wready = 1'b1; w_fire = 1'b1; cnt_w = 0;
          check_eq("wdata", wdata, cur_din);
          check_eq("wstrb", 32'(wstrb), 32'(cur_wen));
          w_data = wdata; w_strb = wstrb;
        end else begin
          cnt_w++; w_wait = 1'b1;
        end
      end

      bvalid = 1'b0; bresp = '0;
      if (b_pend) begin
        if (cnt_b >= b_dly) begin
          bvalid = 1'b1; bresp = b_resp_cfg; b_fire = bready;
        end else cnt_b++;
      end
    end
  end

  // Issue one request at the current negedge (cycle 0) and track it until req_ready.
  task automatic do_req(input logic [31:0] a, input logic [31:0] din, input logic [3:0] wen,
                        input logic [1:0] sz, input logic rw, input bit keep,
                        input bit scramble, output logic [31:0] dout, output int t_ready,
                        output int t_ar, output int n_aw, output int n_w, output int t_b);
    cur_addr = a; cur_din = din; cur_wen = wen; cur_size = sz;
    req_a = a; req_din = din; req_wen = wen; req_size = sz; req_rw = rw; req_strobe = 1'b1;
    t_ready = -1; t_ar = -1; n_aw = 0; n_w = 0; t_b = -1; dout = '0;
    for (int c = 1; c <= 300 && t_ready < 0; c++) begin
      @(negedge clk);
      if (scramble) begin
        req_a = $urandom; req_din = $urandom; req_wen = 4'($urandom);
        req_size = 2'($urandom_range(0, 2)); req_rw = 1'($urandom);
      end
      if (arvalid && t_ar < 0) t_ar = c;
      if (awvalid) n_aw++;
      if (wvalid) n_w++;
      if (bready && t_b < 0) t_b = c;
      if (req_ready) begin t_ready = c; dout = req_dout; end
    end
    if (t_ready < 0) check_eq("req_timeout", 32'd0, 32'd1);
    if (rw) ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], din, wen);
    if (!keep) begin
      req_strobe = 1'b0;
      @(negedge clk);
      check_eq("ready_single", 32'(req_ready), 32'd0);
    end
  endtask

  task automatic set_slave(input int ad, input int rd, input int awd, input int wd,
                           input int bd, input logic [1:0] rr, input logic [1:0] br);
    ar_dly = ad; r_dly = rd; aw_dly = awd; w_dly = wd; b_dly = bd;
    r_resp_cfg = rr; b_resp_cfg = br;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctrl"}, 32'({req_ready, arvalid, rready, awvalid, wvalid, bready, bus_err}),
             32'd0);
    check_eq({tag, "_dout"}, req_dout, 32'd0);
    check_eq({tag, "_addr"}, araddr | awaddr, 32'd0);
    check_eq({tag, "_wr"}, wdata | 32'(wstrb) | 32'(arsize) | 32'(awsize), 32'd0);
  endtask

  initial begin
    logic [31:0] dout, a, din;
    logic [3:0]  wen;
    logic [1:0]  sz;
    logic        rw;
    int t_ready, t_ar, n_aw, n_w, t_b, guard;
    for (int i = 0; i < 16; i++) begin
      smem[i]    = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_1111);
      ref_mem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_1111);
    end
    smem[1] = 32'hDEAD_BEEF; ref_mem[1] = 32'hDEAD_BEEF;
    berr_exp = 1'b0;
    rst = 1'b1; req_strobe = 1'b0; req_a = '0; req_din = '0; req_wen = '0;
    req_size = '0; req_rw = 1'b0;
    cur_addr = '0; cur_din = '0; cur_wen = '0; cur_size = '0;
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait read.
    do_req(32'h0000_1004, 32'h0, 4'h0, 2'd2, 1'b0, 1'b0, 1'b0, dout, t_ready, t_ar, n_aw, n_w, t_b);
    check_eq("rd0_t_ar", 32'(t_ar), 32'd1);
    check_eq("rd0_t_ready", 32'(t_ready), 32'd3);
    check_eq("rd0_dout", dout, 32'hDEAD_BEEF);
    check_eq("rd0_dout_hold", req_dout, 32'hDEAD_BEEF);

    // Write with AW stalled, W immediate.
    set_slave(0, 0, 2, 0, 0, 2'b00, 2'b00);
    do_req(32'h0000_2000, 32'h1234_5678, 4'b0011, 2'd1, 1'b1, 1'b0, 1'b0,
           dout, t_ready, t_ar, n_aw, n_w, t_b);
    check_eq("wr_n_aw", 32'(n_aw), 32'd3);
    check_eq("wr_n_w", 32'(n_w), 32'd1);
    check_eq("wr_t_b", 32'(t_b), 32'd4);
    check_eq("wr_t_ready", 32'(t_ready), 32'd5);
    check_eq("wr_dout_kept", req_dout, 32'hDEAD_BEEF);

    // Write-back then refill with strobe held across the boundary.
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
    do_req(32'h0000_2008, 32'hCAFE_F00D, 4'b1111, 2'd2, 1'b1, 1'b1, 1'b0,
           dout, t_ready, t_ar, n_aw, n_w, t_b);
    check_eq("b2b_wr_t_ready", 32'(t_ready), 32'd3);
    do_req(32'h0000_2008, 32'h0, 4'h0, 2'd2, 1'b0, 1'b0, 1'b0, dout, t_ready, t_ar, n_aw, n_w, t_b);
    check_eq("b2b_rd_t_ar", 32'(t_ar), 32'd2);
    check_eq("b2b_rd_t_ready", 32'(t_ready), 32'd4);
    check_eq("b2b_rd_dout", dout, 32'hCAFE_F00D);

    // Slow R with SLVERR; bus_err sticks across a clean write.
    set_slave(0, 5, 0, 0, 0, 2'b10, 2'b00);
    do_req(32'h0000_2000, 32'h0, 4'h0, 2'd2, 1'b0, 1'b0, 1'b0, dout, t_ready, t_ar, n_aw, n_w, t_b);
    check_eq("slverr_t_ready", 32'(t_ready), 32'd8);
    check_eq("slverr_dout", dout, merge(32'hA5A5_0000, 32'h1234_5678, 4'b0011));
    check_eq("slverr_bus_err", 32'(bus_err), 32'd1);
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
    do_req(32'h0000_200C, 32'h0BAD_F00D, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0,
           dout, t_ready, t_ar, n_aw, n_w, t_b);
    check_eq("berr_sticky", 32'(bus_err), 32'd1);

    // Reset while waiting in the R phase.
    set_slave(0, 10, 0, 0, 0, 2'b00, 2'b00);
    cur_addr = 32'h0000_1004; cur_size = 2'd2;
    req_a = 32'h0000_1004; req_size = 2'd2; req_rw = 1'b0; req_strobe = 1'b1;
    guard = 0;
    while (!rready && guard < 50) begin @(negedge clk); guard++; end
    check_eq("rst_reach_rdata", 32'(rready), 32'd1);
    rst = 1'b1; req_strobe = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00);
    do_req(32'h0000_1004, 32'h0, 4'h0, 2'd2, 1'b0, 1'b0, 1'b0, dout, t_ready, t_ar, n_aw, n_w, t_b);
    check_eq("post_rst_t_ready", 32'(t_ready), 32'd3);
    check_eq("post_rst_dout", dout, 32'hDEAD_BEEF);
    check_eq("post_rst_berr", 32'(bus_err), 32'd0);

    // Randomized traffic against the reference memory.
    for (int n = 0; n < 1000; n++) begin
      if (n == 500) begin
        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        berr_exp = 1'b0;
      end
      a   = 32'h0000_3000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      din = $urandom; wen = 4'($urandom); sz = 2'($urandom_range(0, 2)); rw = 1'($urandom);
      set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00,
                ($urandom_range(0, 15) == 0) ? 2'b11 : 2'b00);
      if (rw) berr_exp = berr_exp | b_resp_cfg[1];
      else    berr_exp = berr_exp | r_resp_cfg[1];
      do_req(a, din, wen, sz, rw, 1'b0, 1'b1, dout, t_ready, t_ar, n_aw, n_w, t_b);
      if (!rw) check_eq("rand_rd_data", dout, ref_mem[a[5:2]]);
      check_eq("rand_bus_err", 32'(bus_err), 32'(berr_exp));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
